// File: rtl/apb_ram_pkg.sv
// apb_ram_pkg: shared FSM state type and address helpers
// for the APB3 RAM controller slice.
package apb_ram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam int ADDR_LSB = 2;

  // Word aligned and inside the RAM; checks every address bit.
  function automatic logic addr_ok(
    input logic [63:0]  addr,
    input int unsigned  depth
  );
    return (addr[ADDR_LSB-1:0] == '0) &&
           ((addr >> ADDR_LSB) < 64'(depth));
  endfunction

endpackage

// File: rtl/apb_ram_ctrl_if.sv
// apb_ram_ctrl_if: APB3 bus bundle between the interconnect
// (master) and the RAM controller (slave).
interface apb_ram_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL,
    output PENABLE,
    output PWRITE,
    output PADDR,
    output PWDATA,
    input  PRDATA,
    input  PREADY,
    input  PSLVERR
  );

  modport slave (
    input  PSEL,
    input  PENABLE,
    input  PWRITE,
    input  PADDR,
    input  PWDATA,
    output PRDATA,
    output PREADY,
    output PSLVERR
  );

endinterface

// File: rtl/apb_ram_subsys.sv
// apb_ram_subsys: APB RAM controller wired to its RAM.
// Exposes only the APB bus and the error counter.
module apb_ram_subsys
  import apb_ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  apb_ram_ctrl_if.slave apb,
  output logic [7:0]    err_cnt
);

  logic                  ram_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  apb_ram_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .WAIT_STATES(WAIT_STATES)
  ) u_ctrl (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .apb      (apb),
    .ram_en   (ram_en),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .err_cnt  (err_cnt)
  );

  apb_slave_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .PCLK  (PCLK),
    .ram_en(ram_en),
    .PADDR (ram_addr),
    .PWDATA(ram_wdata),
    .PRDATA(ram_rdata)
  );

endmodule

// File: rtl/apb_slave_ram.sv
// apb_slave_ram: word-indexed RAM with combinational read and
// a write on the PCLK edge where ram_en is high.
module apb_slave_ram #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  PCLK,
  input  logic                  ram_en,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  hit;
  logic [IW-1:0]         idx;

  assign hit    = PADDR < ADDR_WIDTH'(DEPTH);
  assign idx    = PADDR[IW-1:0];
  assign PRDATA = hit ? mem[idx] : '0;

  always_ff @(posedge PCLK) begin
    if (ram_en && hit) begin
      mem[idx] <= PWDATA;
    end
  end

endmodule

// File: rtl/apb_ram_ctrl.sv
// apb_ram_ctrl: APB3 slave front-end sequencing a word-addressed RAM,
// with programmable wait states and a saturating error counter.
module apb_ram_ctrl
  import apb_ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  apb_ram_ctrl_if.slave         apb,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [7:0]            err_cnt
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
    $error("apb_ram_ctrl: WAIT_STATES must be within 0..15");
  end

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  state_t                state_q;
  state_t                state_d;
  logic [3:0]            cnt_q;
  logic [3:0]            cnt_d;
  logic                  setup;
  logic                  done;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  write_q;
  logic                  err_q;
  logic                  err_d;

  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [7:0]            err_cnt_q;

  assign err_d = !addr_ok(64'(apb.PADDR), unsigned'(DEPTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    setup   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          setup   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!apb.PSEL) begin
          state_d = IDLE;
        end else if (!apb.PENABLE) begin
          setup = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          done    = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (setup) begin
      cnt_d = WS_INIT;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (setup) begin
        addr_q  <= apb.PADDR;
        wdata_q <= apb.PWDATA;
        write_q <= apb.PWRITE;
        err_q   <= err_d;
      end
      // PREADY/PSLVERR live for the single RESP cycle only.
      pready_q  <= done;
      pslverr_q <= done && err_q;
      if (done) begin
        prdata_q <= (!write_q && !err_q) ? ram_rdata : '0;
      end
      if (done && err_q && err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign ram_en    = done && write_q && !err_q;
  assign ram_addr  = addr_q >> ADDR_LSB;
  assign ram_wdata = wdata_q;
  assign err_cnt   = err_cnt_q;

  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_ram_ctrl.sv
// tb_apb_ram_ctrl: three controllers (0, 3 and 2 wait states) with
// bench-side RAMs, checked against a transaction-level model.
`timescale 1ns/1ps
module tb_apb_ram_ctrl;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int N     = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n   [N];
  logic          psel    [N];
  logic          pen     [N];
  logic          pwr     [N];
  logic [AW-1:0] paddr   [N];
  logic [DW-1:0] pwdata  [N];
  logic [DW-1:0] prdata  [N];
  logic          pready  [N];
  logic          pslverr [N];
  logic          ram_en  [N];
  logic [AW-1:0] ram_addr[N];
  logic [DW-1:0] ram_wdata[N];
  logic [DW-1:0] ram_rdata[N];
  logic [7:0]    err_cnt [N];

  logic [DW-1:0] mem [N][DEPTH];
  int            wcnt[N];
  logic [AW-1:0] last_waddr[N];
  bit            clr = 1'b1;

  int n_tot  = 0;
  int n_pass = 0;

  function automatic int ws(int g);
    return (g == 0) ? 0 : ((g == 1) ? 3 : 2);
  endfunction

  function automatic bit legal(logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < DEPTH);
  endfunction

  task automatic chk(string name, int g, logic [63:0] act,
                     logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[dut%0d]: got %0h expected %0h",
                  name, g, act, exp);
  endtask

  for (genvar g = 0; g < N; g++) begin : gi
    localparam int WSV = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
    apb_ram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    assign bus.PSEL    = psel[g];
    assign bus.PENABLE = pen[g];
    assign bus.PWRITE  = pwr[g];
    assign bus.PADDR   = paddr[g];
    assign bus.PWDATA  = pwdata[g];
    assign prdata[g]   = bus.PRDATA;
    assign pready[g]   = bus.PREADY;
    assign pslverr[g]  = bus.PSLVERR;
    assign ram_rdata[g] = mem[g][ram_addr[g][3:0]];

    apb_ram_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .WAIT_STATES(WSV)
    ) dut (
      .PCLK     (clk),
      .PRESETn  (rst_n[g]),
      .apb      (bus),
      .ram_en   (ram_en[g]),
      .ram_addr (ram_addr[g]),
      .ram_wdata(ram_wdata[g]),
      .ram_rdata(ram_rdata[g]),
      .err_cnt  (err_cnt[g])
    );
  end

  // Bench RAMs: write on the edge where ram_en is high.
  always @(posedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (clr) begin
        for (int k = 0; k < DEPTH; k++) mem[g][k] <= '0;
        wcnt[g]       <= 0;
        last_waddr[g] <= '0;
      end else if (ram_en[g]) begin
        mem[g][ram_addr[g][3:0]] <= ram_wdata[g];
        wcnt[g]       <= wcnt[g] + 1;
        last_waddr[g] <= ram_addr[g];
      end
    end
  end

  // Outstanding transaction, owned by the driver.
  bit          pend_v[N];
  bit          pend_w[N];
  logic [31:0] pend_a[N];
  logic [31:0] pend_d[N];

  // Model state, owned by the monitor.
  logic [31:0] mmem[N][DEPTH];
  int          merr[N];
  int          wrote[N];
  bit          minit = 1'b0;

  always @(negedge clk) begin
    if (!minit) begin
      for (int g = 0; g < N; g++)
        for (int k = 0; k < DEPTH; k++) mmem[g][k] = '0;
      minit = 1'b1;
    end
    for (int g = 0; g < N; g++) begin
      if (rst_n[g] !== 1'b1) begin
        merr[g]  = 0;
        wrote[g] = 0;
      end else begin
        if (ram_en[g]) begin
          if (pend_v[g] && pend_w[g] && legal(pend_a[g])) begin
            chk("ram_addr", g, ram_addr[g], pend_a[g] / 4);
            chk("ram_wdata", g, ram_wdata[g], pend_d[g]);
          end else begin
            chk("spurious_ram_en", g, 1, 0);
          end
          wrote[g]++;
        end
        if (pready[g]) begin
          if (!pend_v[g]) begin
            chk("spurious_pready", g, 1, 0);
          end else begin
            bit          e;
            logic [31:0] rexp;
            e    = !legal(pend_a[g]);
            rexp = (pend_w[g] || e) ? 32'h0 : mmem[g][pend_a[g] / 4];
            chk("pslverr", g, pslverr[g], e);
            chk("prdata", g, prdata[g], rexp);
            chk("ram_writes", g, wrote[g], (pend_w[g] && !e) ? 1 : 0);
            if (pend_w[g] && !e) mmem[g][pend_a[g] / 4] = pend_d[g];
            if (e && merr[g] < 255) merr[g]++;
          end
          wrote[g] = 0;
        end else begin
          chk("pslverr_idle", g, pslverr[g], 0);
        end
        chk("err_cnt", g, err_cnt[g], merr[g]);
      end
    end
  end

  task automatic idle(int g);
    @(posedge clk); #1;
    psel[g]   = 1'b0;
    pen[g]    = 1'b0;
    pend_v[g] = 1'b0;
  endtask

  task automatic setup_phase(int g, bit w, logic [31:0] a,
                             logic [31:0] d);
    @(posedge clk); #1;
    psel[g]   = 1'b1;
    pen[g]    = 1'b0;
    pwr[g]    = w;
    paddr[g]  = a;
    pwdata[g] = d;
    pend_v[g] = 1'b1;
    pend_w[g] = w;
    pend_a[g] = a;
    pend_d[g] = d;
  endtask

  // Full transfer; returns read data and setup-to-PREADY cycles.
  task automatic xfer(int g, bit w, logic [31:0] a, logic [31:0] d,
                      output logic [31:0] rd, output int lat);
    setup_phase(g, w, a, d);
    lat = -1;
    rd  = '0;
    for (int c = 0; c < 40; c++) begin
      if (c == 1) pen[g] = 1'b1;
      @(negedge clk);
      if (pready[g]) begin
        lat = c;
        rd  = prdata[g];
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) chk("pready_timeout", g, 1, 0);
    chk("latency", g, lat, 2 + ws(g));
  endtask

  logic [31:0] rd;
  int          lat;
  int          w0;

  initial begin
    for (int g = 0; g < N; g++) begin
      rst_n[g]  = 1'b0;
      psel[g]   = 1'b0;
      pen[g]    = 1'b0;
      pwr[g]    = 1'b0;
      paddr[g]  = '0;
      pwdata[g] = '0;
      pend_v[g] = 1'b0;
      pend_w[g] = 1'b0;
      pend_a[g] = '0;
      pend_d[g] = '0;
    end
    #1;
    for (int g = 0; g < N; g++) begin
      chk("rst_pready", g, pready[g], 0);
      chk("rst_pslverr", g, pslverr[g], 0);
      chk("rst_prdata", g, prdata[g], 0);
      chk("rst_err_cnt", g, err_cnt[g], 0);
      chk("rst_ram_en", g, ram_en[g], 0);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;
    for (int g = 0; g < N; g++) rst_n[g] = 1'b1;

    // No wait states: write then read back.
    xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, rd, lat);
    chk("lit_waddr", 0, last_waddr[0], 2);
    chk("lit_wcnt", 0, wcnt[0], 1);
    xfer(0, 1'b0, 32'h08, 32'h0, rd, lat);
    chk("lit_rd08", 0, rd, 32'hDEADBEEF);
    chk("lit_lat0", 0, lat, 2);
    idle(0);

    // Three wait states.
    xfer(1, 1'b1, 32'h3C, 32'h12345678, rd, lat);
    w0 = wcnt[1];
    xfer(1, 1'b0, 32'h3C, 32'h0, rd, lat);
    chk("lit_rd3c", 1, rd, 32'h12345678);
    chk("lit_lat3", 1, lat, 5);
    chk("lit_no_wr_on_rd", 1, wcnt[1], w0);
    idle(1);

    // Out-of-range and misaligned writes.
    xfer(0, 1'b1, 32'h40, 32'hBAD0BAD0, rd, lat);
    xfer(0, 1'b1, 32'h05, 32'hBAD1BAD1, rd, lat);
    chk("lit_err_cnt2", 0, err_cnt[0], 2);
    chk("lit_err_wcnt", 0, wcnt[0], 1);
    xfer(0, 1'b0, 32'h04, 32'h0, rd, lat);
    chk("lit_rd04", 0, rd, 32'h0);
    xfer(0, 1'b0, 32'h00, 32'h0, rd, lat);
    chk("lit_rd00", 0, rd, 32'h0);
    idle(0);

    // PSEL dropped in the second ACCESS cycle.
    xfer(2, 1'b0, 32'h44, 32'h0, rd, lat);
    xfer(2, 1'b1, 32'h0C, 32'hA5A5A5A5, rd, lat);
    idle(2);
    w0 = wcnt[2];
    setup_phase(2, 1'b1, 32'h0C, 32'h5A5A5A5A);
    @(posedge clk); #1;
    pen[2] = 1'b1;
    @(negedge clk);
    chk("drop_pready_acc", 2, pready[2], 0);
    @(posedge clk); #1;
    psel[2] = 1'b0;
    pen[2]  = 1'b0;
    @(negedge clk);
    chk("drop_pready", 2, pready[2], 0);
    chk("drop_ram_en", 2, ram_en[2], 0);
    idle(2);
    @(negedge clk);
    chk("drop_wcnt", 2, wcnt[2], w0);
    xfer(2, 1'b0, 32'h0C, 32'h0, rd, lat);
    chk("lit_rd0c", 2, rd, 32'hA5A5A5A5);

    // Reset in the middle of an ACCESS phase.
    setup_phase(2, 1'b1, 32'h10, 32'h77778888);
    @(posedge clk); #1;
    pen[2] = 1'b1;
    #2;
    rst_n[2] = 1'b0;
    #1;
    chk("mid_rst_pready", 2, pready[2], 0);
    chk("mid_rst_pslverr", 2, pslverr[2], 0);
    chk("mid_rst_prdata", 2, prdata[2], 0);
    chk("mid_rst_err_cnt", 2, err_cnt[2], 0);
    chk("mid_rst_ram_en", 2, ram_en[2], 0);
    chk("mid_rst_ram_addr", 2, ram_addr[2], 0);
    psel[2]   = 1'b0;
    pen[2]    = 1'b0;
    pend_v[2] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    xfer(2, 1'b0, 32'h10, 32'h0, rd, lat);
    chk("lit_rd10", 2, rd, 32'h0);
    idle(2);

    // Saturate the error counter.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      unique case (i % 3)
        0: a = 32'h8000_0000 | 32'(i * 4);
        1: a = 32'h40 + 32'(i * 4);
        default: a = 32'((i % 16) * 4 + 1);
      endcase
      xfer(0, 1'b0, a, 32'h0, rd, lat);
    end
    chk("lit_err_sat", 0, err_cnt[0], 255);

    // Back-to-back writes then reads across the whole RAM.
    for (int i = 0; i < DEPTH; i++)
      xfer(0, 1'b1, 32'(i * 4), 32'hC0DE0000 + 32'(i) * 32'h00010011,
           rd, lat);
    for (int i = 0; i < DEPTH; i++) begin
      xfer(0, 1'b0, 32'(i * 4), 32'h0, rd, lat);
      chk("b2b_rd", 0, rd, 32'hC0DE0000 + 32'(i) * 32'h00010011);
    end
    idle(0);
    @(negedge clk);
    chk("lit_b2b_wcnt", 0, wcnt[0], 17);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/apb_ram_ctrl.md
Name: apb_ram_ctrl

Overview:
APB3 slave front-end that sequences the word-addressed apb_slave_ram behind it.
Decodes and checks the APB address, inserts a programmable number of wait states, and pulses the RAM write enable exactly once per legal write.
Returns registered read data with PREADY/PSLVERR.
Sits between the APB interconnect and apb_slave_ram; both are instantiated side by side in apb_ram_subsys.

Parameters:
ADDR_WIDTH, 32, APB address width and RAM address port width
DATA_WIDTH, 32, APB and RAM data width
DEPTH, 16, RAM words; legal byte address range 0 .. 4*DEPTH-4
WAIT_STATES, 0, extra ACCESS cycles inserted before completion (0..15)

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous reset, active-low
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1 = write, 0 = read
PADDR  in  ADDR_WIDTH  byte address
PWDATA  in  DATA_WIDTH  write data
PRDATA  out  DATA_WIDTH  registered read data
PREADY  out  1  registered transfer-complete
PSLVERR  out  1  registered error, valid with PREADY
ram_en  out  1  RAM write enable; RAM writes on the same PCLK edge
ram_addr  out  ADDR_WIDTH  RAM word index, zero-extended
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  combinational RAM read data at ram_addr
err_cnt  out  8  saturating count of PSLVERR responses

Behaviour:
- Reset (async, PRESETn=0): state IDLE; PRDATA=0, PREADY=0, PSLVERR=0, err_cnt=0; latched addr/wdata/write=0; ram_en=0 combinationally.
- Reset mid-transfer aborts with no RAM write.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, on PSEL=1 and PENABLE=0 (setup):
  - latch PADDR, PWRITE, PWDATA;
  - err_q = (PADDR[1:0]!=0) or (PADDR>>2 >= DEPTH);
  - cnt = WAIT_STATES;
  - go to ACCESS.
- ACCESS:
  - if PSEL=0: abort to IDLE, no write, no response;
  - else if PENABLE=0: treat as a new setup (relatch, reload cnt, stay in ACCESS);
  - else if cnt!=0: cnt-1;
  - else (cnt==0, PSEL=1, PENABLE=1): set PREADY<=1, PSLVERR<=err_q, PRDATA<=(read and !err_q) ? ram_rdata : 0, and go to RESP.
- ram_en = ACCESS and cnt==0 and PSEL and PENABLE and write_q and !err_q. This is combinational; it is high for exactly one cycle per legal write.
- ram_addr = addr_q>>2 (word index, upper bits 0); ram_wdata = wdata_q. Both are held stable from ACCESS entry through RESP.
- RESP: PREADY=1 for exactly one cycle; next edge sets PREADY<=0, PSLVERR<=0 and goes to IDLE. PRDATA holds its value until the next completion.
- Latency: setup edge to PREADY=1 is 2+WAIT_STATES cycles; the transfer occupies 3+WAIT_STATES cycles including setup.
- Back-to-back transfers: a setup in the cycle after RESP is accepted with no lost cycle.
- Errored writes never assert ram_en. Errored reads return PRDATA=0.
- err_cnt increments on each completion with PSLVERR=1 and saturates at 255.
- Out-of-range detection uses the full PADDR width; high bits set always yields an error.
- WAIT_STATES>15 is illegal; enforce with an elaboration-time assertion.

Decomposition:
- Package apb_ram_pkg:
  - state_t enum {IDLE, ACCESS, RESP};
  - localparam ADDR_LSB=2;
  - function addr_ok(addr, depth).
- Controller is a single module with no sub-module.
- apb_ram_subsys instantiates apb_ram_ctrl and apb_slave_ram, connecting:
  - ram_en to ram_en;
  - ram_addr to PADDR;
  - ram_wdata to PWDATA;
  - PRDATA to ram_rdata.

Test Plan:
- Reset, then WAIT_STATES=0: write 0xDEADBEEF to 0x08 then read 0x08 -> ram_en high for 1 cycle with ram_addr=2; read PRDATA=0xDEADBEEF; PREADY 2 cycles after each setup; PSLVERR=0.
- WAIT_STATES=3: read 0x3C after writing 0x12345678 -> PREADY rises 5 cycles after setup, PRDATA=0x12345678; no ram_en during the read.
- Write to 0x40 (DEPTH=16) and to 0x05 -> PSLVERR=1 with PREADY, ram_en never asserts, RAM contents unchanged; err_cnt=2.
- Drop PSEL in the second ACCESS cycle of a write with WAIT_STATES=2 -> return to IDLE, no PREADY, no ram_en; next read returns the old data.
- Assert PRESETn=0 mid-ACCESS -> all outputs 0 immediately; a following read of the target returns 0.
- 300 errored reads -> err_cnt saturates at 255; 16 back-to-back writes then reads over 0x00..0x3C -> all data matches and no idle cycles are inserted.
